// File: rtl/queue_pkg.sv
// Shared sizing constants for the byte queue and its LIFO sibling.
package queue_pkg;
    localparam int QUEUE_DATA_W = 8;
    localparam int QUEUE_DEPTH  = 16;
    localparam int QUEUE_PTR_W  = $clog2(QUEUE_DEPTH);
    localparam int QUEUE_CNT_W  = $clog2(QUEUE_DEPTH + 1);
endpackage

// File: rtl/queue_mem.sv
// DEPTH x DATA_W register array: one synchronous write port, one registered read port.
module queue_mem
    import queue_pkg::*;
#(
    parameter int DATA_W = QUEUE_DATA_W,
    parameter int DEPTH  = QUEUE_DEPTH,
    parameter int PTR_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [PTR_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [PTR_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // A read and a write to the same slot returns the old contents.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/queue_buffer.sv
// Synchronous FIFO with occupancy count, level flags and sticky error flags.
module queue_buffer
    import queue_pkg::*;
#(
    parameter int DATA_W   = QUEUE_DATA_W,
    parameter int DEPTH    = QUEUE_DEPTH,
    parameter int AFULL_TH = 12
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [DATA_W-1:0]          data_in,
    input  logic                       pop,
    output logic [DATA_W-1:0]          data_out,
    output logic                       data_valid,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       overflow,
    output logic                       underflow,
    input  logic                       clr_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AFULL_CNT = CNT_W'(AFULL_TH);

    if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("queue_buffer: DEPTH must be a power of 2 and >= 4");
    end
    if ((AFULL_TH < 1) || (AFULL_TH > DEPTH)) begin : g_bad_afull
        $error("queue_buffer: AFULL_TH must lie in 1..DEPTH");
    end

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             pop_ok;
    logic             push_ok;

    assign full        = (count == FULL_CNT);
    assign empty       = (count == '0);
    assign almost_full = (count >= AFULL_CNT);

    // A pop frees a slot in the same cycle, so a full queue can still take a push.
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    queue_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .PTR_W  (PTR_W)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (push_ok),
        .waddr (wr_ptr),
        .wdata (data_in),
        .re    (pop_ok),
        .raddr (rd_ptr),
        .rdata (data_out)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            data_valid <= 1'b0;
        end else begin
            data_valid <= pop_ok;
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push_ok && !pop_ok) begin
                count <= count + CNT_W'(1);
            end else if (pop_ok && !push_ok) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    // A fresh error in the clear cycle keeps the flag set.
    always_ff @(posedge clk) begin
        if (!rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push && !push_ok) begin
                overflow <= 1'b1;
            end else if (clr_err) begin
                overflow <= 1'b0;
            end
            if (pop && empty) begin
                underflow <= 1'b1;
            end else if (clr_err) begin
                underflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_queue_buffer.sv
// Scoreboard bench for queue_buffer: a queue-based reference model predicts reads and flags.
module tb_queue_buffer;

    logic       clk = 1'b0;
    logic       rst;
    logic       push;
    logic [7:0] data_in;
    logic       pop;
    logic [7:0] data_out;
    logic       data_valid;
    logic [4:0] count;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       overflow;
    logic       underflow;
    logic       clr_err;

    queue_buffer dut (
        .clk         (clk),
        .rst         (rst),
        .push        (push),
        .data_in     (data_in),
        .pop         (pop),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .count       (count),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .overflow    (overflow),
        .underflow   (underflow),
        .clr_err     (clr_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         tag;
        logic [7:0] data;
        bit         valid;
    } exp_t;

    exp_t       expq[$];
    logic [7:0] mq[$];
    bit         ovf = 1'b0;
    bit         unf = 1'b0;
    int         tests = 0;
    int         fails = 0;
    int         edge_cnt = 0;
    bit         armed = 1'b0;
    bit         done = 1'b0;
    logic [7:0] last_out = 8'h00;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Apply one cycle of stimulus, advance the model, then check state after the edge.
    task automatic step(input bit p, input logic [7:0] d, input bit q, input bit c, input bit r_n);
        exp_t       e;
        bit         pop_ok;
        bit         push_ok;
        int         sz;
        logic [9:0] got;
        logic [9:0] want;
        rst     = r_n;
        push    = p;
        pop     = q;
        data_in = d;
        clr_err = c;
        sz = mq.size();
        if (!r_n) begin
            mq.delete();
            ovf = 1'b0;
            unf = 1'b0;
            e.tag = edge_cnt + 1;
            e.data = 8'h00;
            e.valid = 1'b0;
            expq.push_back(e);
        end else begin
            pop_ok  = q && (sz != 0);
            push_ok = p && ((sz < 16) || pop_ok);
            if (pop_ok) begin
                e.tag = edge_cnt + 1;
                e.data = mq.pop_front();
                e.valid = 1'b1;
                expq.push_back(e);
            end
            if (push_ok) mq.push_back(d);
            if (p && !push_ok) ovf = 1'b1;
            else if (c) ovf = 1'b0;
            if (q && (sz == 0)) unf = 1'b1;
            else if (c) unf = 1'b0;
        end
        @(negedge clk);
        sz = mq.size();
        want = {5'(sz), sz == 16, sz == 0, sz >= 12, ovf, unf};
        got  = {count, full, empty, almost_full, overflow, underflow};
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL state @%0d: got cnt/full/empty/afull/ovf/unf=%b required %b",
                     edge_cnt, got, want);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    endtask

    // Monitor: expected reads are tagged with the clock edge that should present them.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (done) break;
            while (expq.size() > 0 && expq[0].tag < edge_cnt) begin
                e = expq.pop_front();
                tests++;
                fails++;
                $display("FAIL missing_read tag %0d: got nothing required data 0x%02h", e.tag, e.data);
            end
            if (expq.size() > 0 && expq[0].tag == edge_cnt) begin
                e = expq.pop_front();
                tests++;
                if (data_valid !== e.valid || data_out !== e.data) begin
                    fails++;
                    $display("FAIL read @%0d: got valid=%b data=0x%02h required valid=%b data=0x%02h",
                             edge_cnt, data_valid, data_out, e.valid, e.data);
                end
                last_out = e.data;
                armed = 1'b1;
            end else if (armed) begin
                tests++;
                if (data_valid !== 1'b0 || data_out !== last_out) begin
                    fails++;
                    $display("FAIL hold @%0d: got valid=%b data=0x%02h required valid=0 data=0x%02h",
                             edge_cnt, data_valid, data_out, last_out);
                end
            end
        end
    end

    initial begin : driver
        rst = 1'b0; push = 1'b0; pop = 1'b0; data_in = 8'h00; clr_err = 1'b0;
        @(negedge clk);
        step(1'b1, 8'hEE, 1'b1, 1'b1, 1'b0);

        // basic order
        step(1'b1, 8'h11, 1'b0, 1'b0, 1'b1);
        step(1'b1, 8'h22, 1'b0, 1'b0, 1'b1);
        step(1'b1, 8'h33, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        idle(1);

        // fill, overflow, drain twice to wrap the pointers
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0, 1'b1);
            step(1'b1, 8'hAA, 1'b0, 1'b0, 1'b1);
            for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
            step(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        end

        // underflow then clear
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        idle(1);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);

        // push+pop while full
        for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, 1'b1);
        step(1'b1, 8'h55, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);

        // push+pop while empty
        step(1'b1, 8'h77, 1'b1, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);

        // reset mid-operation, push held high through reset
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0, 1'b1);
        step(1'b1, 8'hDD, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h99, 1'b0, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        idle(1);

        // random traffic with alternating push-heavy and pop-heavy phases
        for (int i = 0; i < 3000; i++) begin
            int pw;
            pw = ((i / 250) % 2 == 0) ? 70 : 35;
            step($urandom_range(0, 99) < pw,
                 8'($urandom_range(0, 255)),
                 $urandom_range(0, 99) < 50,
                 $urandom_range(0, 99) < 4,
                 $urandom_range(0, 399) != 0);
        end

        idle(3);
        tests++;
        if (expq.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d reads outstanding required 0", expq.size());
        end
        done = 1'b1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/queue_buffer.md
Name: queue_buffer

Overview:
- Synchronous 16-entry x 8-bit FIFO queue. It is the first-in/first-out counterpart to the team's LIFO stack block: a writer end (push) and an independent reader end (pop).
- Sits between a byte producer and a consumer in the same clock domain.
- Provides occupancy count, full/empty/almost-full flags and sticky overflow/underflow error flags.

Parameters:
- DATA_W, 8, width of each entry
- DEPTH, 16, number of entries; must be a power of 2, >= 4
- AFULL_TH, 12, almost_full asserts when count >= AFULL_TH; 1 <= AFULL_TH <= DEPTH

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-low reset
- push  input  1  write request
- data_in  input  DATA_W  write data, sampled when push is accepted
- pop  input  1  read request
- data_out  output  DATA_W  read data, registered
- data_valid  output  1  one-cycle pulse: data_out updated this cycle
- count  output  $clog2(DEPTH+1)  current occupancy, 0..DEPTH
- full  output  1  count == DEPTH
- empty  output  1  count == 0
- almost_full  output  1  count >= AFULL_TH
- overflow  output  1  sticky: push rejected
- underflow  output  1  sticky: pop rejected
- clr_err  input  1  clears overflow/underflow

Behaviour:
- Reset (rst == 0 at a rising edge):
  - wr_ptr = 0, rd_ptr = 0, count = 0.
  - data_out = 0, data_valid = 0, overflow = 0, underflow = 0.
  - Reset wins over every other input.
  - Memory contents are not cleared.
  - Reset mid-operation discards all queued data; the first post-reset pop of pushed data returns the oldest entry pushed after reset.
- Pop acceptance:
  - pop_ok = pop && !empty.
  - On pop_ok: data_out <= mem[rd_ptr], data_valid <= 1, rd_ptr <= rd_ptr + 1.
  - Latency is 1 cycle from the pop edge to data_out/data_valid.
  - Otherwise data_valid <= 0 and data_out holds its value.
- Push acceptance:
  - push_ok = push && (!full || pop_ok).
  - On push_ok: mem[wr_ptr] <= data_in, wr_ptr <= wr_ptr + 1.
- Pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Count update:
  - +1 when push_ok && !pop_ok.
  - -1 when pop_ok && !push_ok.
  - Unchanged when both or neither are accepted.
- Flags full, empty and almost_full are combinational decodes of the registered count.
- Simultaneous events:
  - push && pop while full: both accepted; count stays DEPTH; the oldest entry is read; no overflow.
  - push && pop while empty: push accepted, pop rejected (no bypass); count becomes 1; underflow sets; data_valid = 0.
  - push && pop otherwise: both accepted; count unchanged.
- Errors:
  - overflow <= 1 when push && !push_ok.
  - underflow <= 1 when pop && empty.
  - clr_err clears both flags the next cycle. A new error event in the same cycle as clr_err takes priority, so the flag stays 1.
  - The queue state is never corrupted by a rejected request.
- No internal FSM beyond the pointer/count registers. Each cycle is decided independently from the current count.

Decomposition:
- Shared package queue_pkg:
  - QUEUE_DATA_W = 8
  - QUEUE_DEPTH = 16
  - QUEUE_PTR_W = $clog2(QUEUE_DEPTH)
  - QUEUE_CNT_W = $clog2(QUEUE_DEPTH+1)
- Defaults of both the stack block and this block reference the package.
- One sub-module: queue_mem, a DEPTH x DATA_W register array with one synchronous write port and one registered read port. Pointer, count, flag and error logic stay in queue_buffer.

Test Plan:
- Reset, then push 0x11, 0x22, 0x33 on consecutive cycles, then pop x3 -> data_out = 0x11, 0x22, 0x33 on the three cycles after each pop edge; data_valid pulses each time; count goes 3 -> 0; empty = 1 at the end.
- Push 16 values 0x00..0x0F -> almost_full = 1 once count = 12; full = 1 at count = 16. A 17th push of 0xAA -> overflow = 1, count stays 16. Pop x16 -> 0x00..0x0F in order (pointer wrap exercised by a second fill/drain cycle).
- Pop while empty -> underflow = 1, data_valid = 0, data_out unchanged. Then clr_err = 1 for one cycle -> underflow = 0.
- Fill to 16, then push 0x55 && pop in the same cycle -> data_out = oldest entry, count = 16, overflow = 0. Drain -> 0x55 is the last value out.
- Empty queue, push 0x77 && pop in the same cycle -> count = 1, underflow = 1, data_valid = 0. The next pop returns 0x77.
- Push 5 values, assert rst = 0 for one cycle with push = 1 -> count = 0, empty = 1, flags = 0. Push 0x99, pop -> 0x99.
